fpro_bus_arbiter: RTL and testbench

// - Shares the single FPro bus (mmio/video slots) between two masters.
// - m0 is the MCS bridge side; m1 is a secondary master (DMA or debug UART).
// - Each transfer is latched, issued to the bus as a one-cycle strobe, then acked with read data.
// - Round-robin arbitration; optional bus lock for atomic read-modify-write.

---
 rtl/fpro_bus_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_fpro_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpro_bus_arbiter.sv
// fpro_bus_arbiter: shares the FPro bus between two masters (m0 = MCS bridge,
// m1 = secondary master). Round-robin grant, one transfer every three cycles:
// IDLE (arbitrate and latch) -> ISSUE (one-cycle bus strobe) -> ACK (pulse + read data).
// Optional feature macro FPRO_ARB_LOCK_EN adds mX_lock ports. A transfer latched with
// lock=1 keeps the bus reserved for the same master until one of its transfers
// latched with lock=0 completes.
module fpro_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_video,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
`ifdef FPRO_ARB_LOCK_EN
    input  logic              m0_lock,
`endif
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic              m1_video,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
`ifdef FPRO_ARB_LOCK_EN
    input  logic              m1_lock,
`endif
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              fp_mmio_cs,
    output logic              fp_video_cs,
    output logic              fp_write,
    output logic              fp_read,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [DATA_W-1:0] fp_write_data,
    input  logic [DATA_W-1:0] fp_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              wr_q, wr_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              fp_mmio_cs_q, fp_mmio_cs_d;
    logic              fp_video_cs_q, fp_video_cs_d;
    logic              fp_write_q, fp_write_d;
    logic              fp_read_q, fp_read_d;
    logic [ADDR_W-1:0] fp_addr_q, fp_addr_d;
    logic [DATA_W-1:0] fp_write_data_q, fp_write_data_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rd_data_q, m0_rd_data_d;
    logic [DATA_W-1:0] m1_rd_data_q, m1_rd_data_d;
`ifdef FPRO_ARB_LOCK_EN
    logic              lock_q, lock_d;
    logic              locked_q, locked_d;
`endif

    logic              req0_s;
    logic              req1_s;
    logic              next_gnt_s;

    // Qualify requests (a held lock masks the other master) and pick the round-robin winner.
    always_comb begin
        req0_s = m0_req;
        req1_s = m1_req;
`ifdef FPRO_ARB_LOCK_EN
        if (locked_q) begin
            if (last_grant_q) begin
                req0_s = 1'b0;
            end else begin
                req1_s = 1'b0;
            end
        end else begin
            req0_s = m0_req;
            req1_s = m1_req;
        end
`endif
        if (req0_s && req1_s) begin
            next_gnt_s = ~last_grant_q;
        end else begin
            next_gnt_s = req1_s;
        end
    end

    // Next-state and next-output computation for the IDLE/ISSUE/ACK sequence.
    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        wr_d            = wr_q;
        last_grant_d    = last_grant_q;
        rd_d            = rd_q;
        fp_mmio_cs_d    = 1'b0;
        fp_video_cs_d   = 1'b0;
        fp_write_d      = 1'b0;
        fp_read_d       = 1'b0;
        fp_addr_d       = {ADDR_W{1'b0}};
        fp_write_data_d = {DATA_W{1'b0}};
        m0_ack_d        = 1'b0;
        m1_ack_d        = 1'b0;
        m0_rd_data_d    = {DATA_W{1'b0}};
        m1_rd_data_d    = {DATA_W{1'b0}};
`ifdef FPRO_ARB_LOCK_EN
        lock_d          = lock_q;
        locked_d        = locked_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0_s || req1_s) begin
                    gnt_d           = next_gnt_s;
                    wr_d            = next_gnt_s ? m1_wr : m0_wr;
                    fp_mmio_cs_d    = next_gnt_s ? ~m1_video : ~m0_video;
                    fp_video_cs_d   = next_gnt_s ? m1_video : m0_video;
                    fp_write_d      = next_gnt_s ? m1_wr : m0_wr;
                    fp_read_d       = next_gnt_s ? ~m1_wr : ~m0_wr;
                    fp_addr_d       = next_gnt_s ? m1_addr : m0_addr;
                    fp_write_data_d = next_gnt_s ? m1_wr_data : m0_wr_data;
`ifdef FPRO_ARB_LOCK_EN
                    lock_d          = next_gnt_s ? m1_lock : m0_lock;
`endif
                    state_d         = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The slot drives read data combinationally during the strobe cycle.
                if (!wr_q) begin
                    rd_d = fp_read_data;
                end else begin
                    rd_d = rd_q;
                end
                if (gnt_q) begin
                    m1_ack_d     = 1'b1;
                    m1_rd_data_d = rd_d;
                end else begin
                    m0_ack_d     = 1'b1;
                    m0_rd_data_d = rd_d;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                last_grant_d = gnt_q;
`ifdef FPRO_ARB_LOCK_EN
                locked_d     = lock_q;
`endif
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transfer and drops every strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            gnt_q           <= 1'b0;
            wr_q            <= 1'b0;
            last_grant_q    <= 1'b1;
            rd_q            <= {DATA_W{1'b0}};
            fp_mmio_cs_q    <= 1'b0;
            fp_video_cs_q   <= 1'b0;
            fp_write_q      <= 1'b0;
            fp_read_q       <= 1'b0;
            fp_addr_q       <= {ADDR_W{1'b0}};
            fp_write_data_q <= {DATA_W{1'b0}};
            m0_ack_q        <= 1'b0;
            m1_ack_q        <= 1'b0;
            m0_rd_data_q    <= {DATA_W{1'b0}};
            m1_rd_data_q    <= {DATA_W{1'b0}};
`ifdef FPRO_ARB_LOCK_EN
            lock_q          <= 1'b0;
            locked_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            wr_q            <= wr_d;
            last_grant_q    <= last_grant_d;
            rd_q            <= rd_d;
            fp_mmio_cs_q    <= fp_mmio_cs_d;
            fp_video_cs_q   <= fp_video_cs_d;
            fp_write_q      <= fp_write_d;
            fp_read_q       <= fp_read_d;
            fp_addr_q       <= fp_addr_d;
            fp_write_data_q <= fp_write_data_d;
            m0_ack_q        <= m0_ack_d;
            m1_ack_q        <= m1_ack_d;
            m0_rd_data_q    <= m0_rd_data_d;
            m1_rd_data_q    <= m1_rd_data_d;
`ifdef FPRO_ARB_LOCK_EN
            lock_q          <= lock_d;
            locked_q        <= locked_d;
`endif
        end
    end

    assign m0_ack        = m0_ack_q;
    assign m1_ack        = m1_ack_q;
    assign m0_rd_data    = m0_rd_data_q;
    assign m1_rd_data    = m1_rd_data_q;
    assign fp_mmio_cs    = fp_mmio_cs_q;
    assign fp_video_cs   = fp_video_cs_q;
    assign fp_write      = fp_write_q;
    assign fp_read       = fp_read_q;
    assign fp_addr       = fp_addr_q;
    assign fp_write_data = fp_write_data_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Bench for fpro_bus_arbiter: directed scenarios with literal expectations, then
// randomized masters checked every cycle against a transaction-level model.
module tb_fpro_bus_arbiter;
    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset;
    logic m0_req, m0_wr, m0_video, m1_req, m1_wr, m1_video;
    logic [ADDR_W-1:0] m0_addr, m1_addr, fp_addr;
    logic [DATA_W-1:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
    logic [DATA_W-1:0] fp_write_data, fp_read_data;
    logic m0_ack, m1_ack, fp_mmio_cs, fp_video_cs, fp_write, fp_read;
`ifdef FPRO_ARB_LOCK_EN
    logic m0_lock, m1_lock;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    fpro_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_video(m0_video), .m0_addr(m0_addr),
        .m0_wr_data(m0_wr_data),
`ifdef FPRO_ARB_LOCK_EN
        .m0_lock(m0_lock),
`endif
        .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_video(m1_video), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data),
`ifdef FPRO_ARB_LOCK_EN
        .m1_lock(m1_lock),
`endif
        .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
        .fp_mmio_cs(fp_mmio_cs), .fp_video_cs(fp_video_cs), .fp_write(fp_write),
        .fp_read(fp_read), .fp_addr(fp_addr), .fp_write_data(fp_write_data),
        .fp_read_data(fp_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Waits (bounded) for the next ack pulse and reports which master got it.
    task automatic wait_ack(input string name, input int budget, output int who);
        who = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (m0_ack) begin who = 0; break; end
            if (m1_ack) begin who = 1; break; end
        end
        if (who < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no ack within %0d cycles", name, budget);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // A granted transfer occupies the bus in the cycle after arbitration and is
    // acknowledged one cycle later; arbitration resumes in the cycle after the ack.
    typedef struct {
        bit                g;
        bit                wr;
        bit                vid;
        bit                lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } txn_t;

    txn_t cur;
    bit   active     = 1'b0;
    bit   last_grant = 1'b1;
    bit   locked     = 1'b0;
    int   t_issue    = 0;
    int   free_at    = 0;

    logic              e_mmio, e_vid, e_wr, e_rd, e_ack0, e_ack1, skip_rd;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_rd0, e_rd1;

    initial begin
        forever begin
            @(negedge clk);
            e_mmio = 1'b0; e_vid = 1'b0; e_wr = 1'b0; e_rd = 1'b0;
            e_ack0 = 1'b0; e_ack1 = 1'b0; skip_rd = 1'b0;
            e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
            if (!reset) begin
                active = 1'b0; last_grant = 1'b1; locked = 1'b0; free_at = 0;
            end else if (active && cyc == t_issue) begin
                e_mmio = !cur.vid; e_vid = cur.vid; e_wr = cur.wr; e_rd = !cur.wr;
                e_addr = cur.addr; e_wdata = cur.wdata;
                if (!cur.wr) cur.rdata = fp_read_data;
            end else if (active && cyc == t_issue + 1) begin
                if (cur.g) begin e_ack1 = 1'b1; e_rd1 = cur.rdata; end
                else       begin e_ack0 = 1'b1; e_rd0 = cur.rdata; end
                skip_rd    = cur.wr;
                last_grant = cur.g;
                locked     = cur.lock;
                active     = 1'b0;
                free_at    = cyc + 1;
            end
            chk("m_mmio_cs",  64'(fp_mmio_cs),    64'(e_mmio));
            chk("m_video_cs", 64'(fp_video_cs),   64'(e_vid));
            chk("m_write",    64'(fp_write),      64'(e_wr));
            chk("m_read",     64'(fp_read),       64'(e_rd));
            chk("m_addr",     64'(fp_addr),       64'(e_addr));
            chk("m_wdata",    64'(fp_write_data), 64'(e_wdata));
            chk("m_ack0",     64'(m0_ack),        64'(e_ack0));
            chk("m_ack1",     64'(m1_ack),        64'(e_ack1));
            if (!(e_ack0 && skip_rd)) chk("m_rd0", 64'(m0_rd_data), 64'(e_rd0));
            if (!(e_ack1 && skip_rd)) chk("m_rd1", 64'(m1_rd_data), 64'(e_rd1));
            if (reset && !active && cyc >= free_at) begin
                bit r0, r1, g;
                r0 = m0_req; r1 = m1_req;
                if (locked) begin
                    if (last_grant) r0 = 1'b0; else r1 = 1'b0;
                end
                if (r0 || r1) begin
                    g         = (r0 && r1) ? !last_grant : r1;
                    cur.g     = g;
                    cur.wr    = g ? m1_wr : m0_wr;
                    cur.vid   = g ? m1_video : m0_video;
                    cur.addr  = g ? m1_addr : m0_addr;
                    cur.wdata = g ? m1_wr_data : m0_wr_data;
                    cur.rdata = '0;
`ifdef FPRO_ARB_LOCK_EN
                    cur.lock  = g ? m1_lock : m0_lock;
`else
                    cur.lock  = 1'b0;
`endif
                    t_issue   = cyc + 1;
                    active    = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int who, t0, tc;
        logic a0, a1;
        reset = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_video = 1'b0; m0_addr = '0; m0_wr_data = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_video = 1'b0; m1_addr = '0; m1_wr_data = '0;
`ifdef FPRO_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        fp_read_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset strobes", 64'({fp_mmio_cs, fp_video_cs, fp_write, fp_read}), 64'(0));
        chk("reset acks",    64'({m0_ack, m1_ack}), 64'(0));

        // Single read by m0 from the mmio slot.
        @(posedge clk); #1;
        reset = 1'b1;
        m0_wr = 1'b0; m0_video = 1'b0; m0_addr = 21'h00040; m0_req = 1'b1;
        fp_read_data = 32'hDEADBEEF;
        t0 = cyc;
        @(negedge clk);
        @(negedge clk);
        chk("rd fp_read",    64'({fp_read, fp_mmio_cs, fp_video_cs, fp_write}), 64'(4'b1100));
        chk("rd fp_addr",    64'(fp_addr), 64'(21'h00040));
        @(negedge clk);
        chk("rd ack cycle",  64'(cyc - t0), 64'(2));
        chk("rd m0_ack",     64'({m0_ack, m1_ack}), 64'(2'b10));
        chk("rd m0_rd_data", 64'(m0_rd_data), 64'(32'hDEADBEEF));
        @(posedge clk); #1;
        m0_req = 1'b0;

        // Video write by m1.
        m1_wr = 1'b1; m1_video = 1'b1; m1_addr = 21'h00123; m1_wr_data = 32'h12345678; m1_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("vw strobes", 64'({fp_read, fp_mmio_cs, fp_video_cs, fp_write}), 64'(4'b0011));
        chk("vw wdata",   64'(fp_write_data), 64'(32'h12345678));
        @(negedge clk);
        chk("vw acks",    64'({m0_ack, m1_ack}), 64'(2'b01));
        @(posedge clk); #1;
        m1_req = 1'b0;

        // Contention: both requests held from reset release.
        @(posedge clk); #1;
        reset = 1'b0;
        m0_wr = 1'b0; m0_video = 1'b0; m0_addr = 21'h00100; m0_req = 1'b1;
        m1_wr = 1'b1; m1_video = 1'b0; m1_addr = 21'h00200; m1_wr_data = 32'hA5A5A5A5; m1_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        tc = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_ack("contention", 6, who);
            chk("contention grant",     64'(who), 64'(k % 2));
            chk("contention ack cycle", 64'(cyc), 64'(tc + 2 + 3 * k));
        end

        // Reset asserted during ISSUE of the next (m0 read) transfer.
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre-reset issue", 64'(fp_read), 64'(1));
        reset = 1'b0;
        #1;
        chk("async strobe drop", 64'({fp_mmio_cs, fp_video_cs, fp_write, fp_read}), 64'(0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("no ack in reset", 64'({m0_ack, m1_ack}), 64'(0));
        end
        @(posedge clk); #1;
        reset = 1'b1;
        wait_ack("post-reset", 6, who);
        chk("post-reset tie grant", 64'(who), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

`ifdef FPRO_ARB_LOCK_EN
        // Locked read-modify-write by m0 while m1 keeps requesting.
        m0_wr = 1'b0; m0_lock = 1'b1; m0_req = 1'b1;
        m1_wr = 1'b1; m1_lock = 1'b0; m1_req = 1'b1;
        wait_ack("lock rd", 6, who);
        chk("lock rd grant", 64'(who), 64'(0));
        @(posedge clk); #1;
        m0_req = 1'b0;
        @(posedge clk); #1;
        m0_wr = 1'b1; m0_lock = 1'b0; m0_req = 1'b1;
        wait_ack("lock wr", 8, who);
        chk("lock wr grant", 64'(who), 64'(0));
        @(posedge clk); #1;
        m0_req = 1'b0;
        wait_ack("lock release", 8, who);
        chk("lock release grant", 64'(who), 64'(1));
        @(posedge clk); #1;
        m1_req = 1'b0;
`endif

        // Randomized masters; reset pulses occasionally.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a0 = m0_ack;
            a1 = m1_ack;
            @(posedge clk); #1;
            fp_read_data = $urandom;
            reset = ($urandom_range(0, 399) != 0);
            if (m0_req) begin
                if (a0) m0_req = 1'b0;
                else if ($urandom_range(0, 7) == 0) m0_addr = ADDR_W'($urandom);
            end else if ($urandom_range(0, 2) == 0) begin
                m0_req = 1'b1; m0_wr = 1'($urandom_range(0, 1)); m0_video = 1'($urandom_range(0, 1));
                m0_addr = ADDR_W'($urandom); m0_wr_data = $urandom;
`ifdef FPRO_ARB_LOCK_EN
                m0_lock = ($urandom_range(0, 3) == 0);
`endif
            end
            if (m1_req) begin
                if (a1) m1_req = 1'b0;
                else if ($urandom_range(0, 7) == 0) m1_wr_data = $urandom;
            end else if ($urandom_range(0, 2) == 0) begin
                m1_req = 1'b1; m1_wr = 1'($urandom_range(0, 1)); m1_video = 1'($urandom_range(0, 1));
                m1_addr = ADDR_W'($urandom); m1_wr_data = $urandom;
`ifdef FPRO_ARB_LOCK_EN
                m1_lock = ($urandom_range(0, 3) == 0);
`endif
            end
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
